// File: rtl/warships_pkg.sv
// Shared warships definitions: board geometry defaults, cell-state encoding
// and the board_writer FSM state constants.
package warships_pkg;

  localparam int GRID_CELL_SIZE    = 32;
  localparam int GRID_X_SIZE       = 12;
  localparam int GRID_Y_SIZE       = 12;
  localparam int GRID_X_ADDR_WIDTH = 4;
  localparam int GRID_Y_ADDR_WIDTH = 4;
  localparam int CELL_DATA_WIDTH   = 2;

  typedef enum logic [1:0] {
    EMPTY     = 2'b00,
    SHIP      = 2'b01,
    SHOT_HIT  = 2'b10,
    SHOT_MISS = 2'b11
  } cell_t;

  typedef logic [1:0] state_t;
  localparam state_t CLEAR = 2'd0;
  localparam state_t IDLE  = 2'd1;
  localparam state_t CHECK = 2'd2;
  localparam state_t WRITE = 2'd3;

endpackage

// File: rtl/click_sync.sv
// Two-flop synchronizer for a mouse button level plus a rising-edge detector
// producing a one-cycle press pulse in the clk domain.
module click_sync (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic press
);

  logic sync1;
  logic sync2;
  logic sync2_q;

  // NOTE: non-blocking assignments let every stage take the previous stage's
  // old value, so the three flops form a true shift chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1   <= button;
      sync2   <= sync1;
      sync2_q <= sync2;
    end
  end

  assign press = sync2 & ~sync2_q;

endmodule

// File: rtl/board_writer.sv
// Write-side controller for board_mem: clears the board after reset or on
// request and turns left-clicks over the grid into single-cycle cell writes.
// Optional macro BOARD_WRITER_RIGHT_ERASE_EN adds a right-click erase input.
module board_writer
  import warships_pkg::*;
#(
  parameter int X_POS        = 100,
  parameter int Y_POS        = 200,
  parameter int CELL_SIZE    = GRID_CELL_SIZE,
  parameter int X_SIZE       = GRID_X_SIZE,
  parameter int Y_SIZE       = GRID_Y_SIZE,
  parameter int X_ADDR_WIDTH = GRID_X_ADDR_WIDTH,
  parameter int Y_ADDR_WIDTH = GRID_Y_ADDR_WIDTH,
  parameter int DATA_WIDTH   = CELL_DATA_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [11:0]                        mouse_x_pos,
  input  logic [11:0]                        mouse_y_pos,
  input  logic                               mouse_left,
`ifdef BOARD_WRITER_RIGHT_ERASE_EN
  input  logic                               mouse_right,
`endif
  input  logic                               enable,
  input  logic                               clear_req,
  input  logic [DATA_WIDTH-1:0]              write_value,
  output logic [Y_ADDR_WIDTH+X_ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0]              write_data,
  output logic                               write_enable,
  output logic                               busy,
  output logic                               click_hit,
  output logic                               click_miss
);

  localparam int SHIFT = $clog2(CELL_SIZE);
  localparam logic signed [12:0] X_OFF  = 13'(X_POS);
  localparam logic signed [12:0] Y_OFF  = 13'(Y_POS);
  localparam logic signed [12:0] X_SPAN = 13'(X_SIZE * CELL_SIZE);
  localparam logic signed [12:0] Y_SPAN = 13'(Y_SIZE * CELL_SIZE);
  localparam logic [X_ADDR_WIDTH-1:0] COL_LAST = X_ADDR_WIDTH'(X_SIZE - 1);
  localparam logic [Y_ADDR_WIDTH-1:0] ROW_LAST = Y_ADDR_WIDTH'(Y_SIZE - 1);

  state_t                  state;
  logic [X_ADDR_WIDTH-1:0] col;
  logic [Y_ADDR_WIDTH-1:0] row;
  logic [11:0]             x_q;
  logic [11:0]             y_q;
  logic                    left_press;
  logic                    click;
  logic                    erase;
  logic signed [12:0]      dx;
  logic signed [12:0]      dy;
  logic                    hit;
  logic [DATA_WIDTH-1:0]   hit_data;

  click_sync u_left_sync (
    .clk    (clk),
    .rst    (rst),
    .button (mouse_left),
    .press  (left_press)
  );

`ifdef BOARD_WRITER_RIGHT_ERASE_EN
  logic right_press;

  click_sync u_right_sync (
    .clk    (clk),
    .rst    (rst),
    .button (mouse_right),
    .press  (right_press)
  );

  assign click = left_press | right_press;

  // A simultaneous left edge wins, so erase only when the left edge is absent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      erase <= 1'b0;
    end else if (state == IDLE && !clear_req && click && enable) begin
      erase <= ~left_press;
    end
  end
`else
  assign click = left_press;
  assign erase = 1'b0;
`endif

  // Pointer offsets from the board origin; negative means left of / above it.
  assign dx       = $signed({1'b0, x_q}) - X_OFF;
  assign dy       = $signed({1'b0, y_q}) - Y_OFF;
  assign hit      = (dx >= 13'sd0) && (dx < X_SPAN) && (dy >= 13'sd0) && (dy < Y_SPAN);
  assign hit_data = erase ? DATA_WIDTH'(EMPTY) : write_value;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= CLEAR;
      row          <= '0;
      col          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      write_addr   <= '0;
      write_data   <= '0;
      write_enable <= 1'b0;
      busy         <= 1'b0;
      click_hit    <= 1'b0;
      click_miss   <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      busy         <= 1'b0;
      click_hit    <= 1'b0;
      click_miss   <= 1'b0;
      case (state)
        CLEAR: begin
          write_enable <= 1'b1;
          busy         <= 1'b1;
          write_addr   <= {row, col};
          write_data   <= DATA_WIDTH'(EMPTY);
          if (col == COL_LAST) begin
            col <= '0;
            if (row == ROW_LAST) begin
              row   <= '0;
              state <= IDLE;
            end else begin
              row <= row + 1'b1;
            end
          end else begin
            col <= col + 1'b1;
          end
        end
        IDLE: begin
          if (clear_req) begin
            row   <= '0;
            col   <= '0;
            state <= CLEAR;
          end else if (click && enable) begin
            x_q   <= mouse_x_pos;
            y_q   <= mouse_y_pos;
            state <= CHECK;
          end
        end
        // Outputs are registered here so they are valid throughout WRITE.
        CHECK: begin
          if (hit) begin
            write_enable <= 1'b1;
            write_addr   <= {dy[SHIFT +: Y_ADDR_WIDTH], dx[SHIFT +: X_ADDR_WIDTH]};
            write_data   <= hit_data;
            click_hit    <= 1'b1;
          end else begin
            click_miss <= 1'b1;
          end
          state <= WRITE;
        end
        WRITE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_writer.sv
// Self-checking bench for board_writer: clear sweeps, click latency, table
// vectors, held button, randomized clicks against a geometric reference model.
module tb_board_writer;
  import warships_pkg::*;

  localparam int BX = 100;
  localparam int BY = 200;
  localparam int CS = 32;
  localparam int NX = 12;
  localparam int NY = 12;
  localparam int NCELLS = NX * NY;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] mouse_x_pos = '0;
  logic [11:0] mouse_y_pos = '0;
  logic        mouse_left = 1'b0;
  logic        mouse_right = 1'b0;
  logic        enable = 1'b0;
  logic        clear_req = 1'b0;
  logic [1:0]  write_value = '0;
  logic [7:0]  write_addr;
  logic [1:0]  write_data;
  logic        write_enable;
  logic        busy;
  logic        click_hit;
  logic        click_miss;

  board_writer dut (
    .clk          (clk),
    .rst          (rst),
    .mouse_x_pos  (mouse_x_pos),
    .mouse_y_pos  (mouse_y_pos),
    .mouse_left   (mouse_left),
`ifdef BOARD_WRITER_RIGHT_ERASE_EN
    .mouse_right  (mouse_right),
`endif
    .enable       (enable),
    .clear_req    (clear_req),
    .write_value  (write_value),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_enable (write_enable),
    .busy         (busy),
    .click_hit    (click_hit),
    .click_miss   (click_miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [1:0] data;
    int         cyc;
  } wr_t;

  typedef struct {
    int         x;
    int         y;
    logic [1:0] value;
    logic       en;
    int         kind;   // 0 = nothing, 1 = hit, 2 = miss
    logic [7:0] addr;
  } vec_t;

  wr_t wr_q[$];
  int  cyc = 0;
  int  n_hit = 0;
  int  n_miss = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst && write_enable) wr_q.push_back('{write_addr, write_data, cyc});
    if (rst && click_hit) n_hit++;
    if (rst && click_miss) n_miss++;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Reference: pixel offset from the board origin, divided by the cell pitch.
  function automatic void model(input int x, input int y, output bit is_hit, output int addr);
    int dx;
    int dy;
    dx = x - BX;
    dy = y - BY;
    is_hit = (dx >= 0) && (dx < NX * CS) && (dy >= 0) && (dy < NY * CS);
    addr = is_hit ? (dy / CS) * 16 + (dx / CS) : 0;
  endfunction

  task automatic do_click(input int x, input int y, input logic [1:0] v, input logic en, input int hold);
    @(negedge clk);
    mouse_x_pos = 12'(x);
    mouse_y_pos = 12'(y);
    write_value = v;
    enable      = en;
    mouse_left  = 1'b1;
    repeat (hold) @(negedge clk);
    mouse_left = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_sweep(input string tag);
    int n;
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  task automatic check_sweep(input string tag, input int base);
    int bad;
    int exp_addr;
    bad = 0;
    check({tag, "_writes"}, 32'(wr_q.size() - base), 32'(NCELLS));
    for (int i = 0; i < NCELLS && base + i < wr_q.size(); i++) begin
      exp_addr = (i / NX) * 16 + (i % NX);
      if (wr_q[base + i].addr !== 8'(exp_addr) || wr_q[base + i].data !== 2'b00) bad++;
    end
    check({tag, "_order_bad"}, 32'(bad), 32'd0);
    if (wr_q.size() - base >= NCELLS)
      check({tag, "_span"}, 32'(wr_q[base + NCELLS - 1].cyc - wr_q[base].cyc), 32'(NCELLS - 1));
  endtask

  initial begin
    vec_t vecs[8];
    int   base;
    int   h0;
    int   m0;
    int   n;
    logic we_hist[6];
    logic hit_hist[6];
    logic [7:0] addr4;
    logic [1:0] data4;

    vecs[0] = '{201, 425, SHIP,  1'b1, 1, 8'h73};
    vecs[1] = '{ 99, 200, SHIP,  1'b1, 2, 8'h00};
    vecs[2] = '{484, 300, SHIP,  1'b1, 2, 8'h00};
    vecs[3] = '{483, 583, 2'b10, 1'b1, 1, 8'hBB};
    vecs[4] = '{100, 200, 2'b11, 1'b1, 1, 8'h00};
    vecs[5] = '{100, 199, SHIP,  1'b1, 2, 8'h00};
    vecs[6] = '{483, 584, SHIP,  1'b1, 2, 8'h00};
    vecs[7] = '{201, 425, SHIP,  1'b0, 0, 8'h00};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_we", 32'(write_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(write_addr), 32'd0);
    check("rst_data", 32'(write_data), 32'd0);
    check("rst_hit", 32'(click_hit), 32'd0);
    check("rst_miss", 32'(click_miss), 32'd0);

    // Power-up clear sweep.
    base = wr_q.size();
    rst = 1'b1;
    wait_sweep("init");
    check_sweep("init", base);
    check("init_we_after", 32'(write_enable), 32'd0);

    // Click latency: write_enable in the cycle after edge 4, one cycle wide.
    @(negedge clk);
    mouse_x_pos = 12'd201;
    mouse_y_pos = 12'd425;
    write_value = SHIP;
    enable      = 1'b1;
    mouse_left  = 1'b1;
    addr4 = '0;
    data4 = '0;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      @(negedge clk);
      we_hist[e]  = write_enable;
      hit_hist[e] = click_hit;
      if (e == 4) begin
        addr4 = write_addr;
        data4 = write_data;
      end
    end
    check("lat_we_e3", 32'(we_hist[3]), 32'd0);
    check("lat_we_e4", 32'(we_hist[4]), 32'd1);
    check("lat_we_e5", 32'(we_hist[5]), 32'd0);
    check("lat_hit_e4", 32'(hit_hist[4]), 32'd1);
    check("lat_hit_e5", 32'(hit_hist[5]), 32'd0);
    check("lat_addr", 32'(addr4), 32'h73);
    check("lat_data", 32'(data4), 32'(SHIP));
    check("lat_addr_hold", 32'(write_addr), 32'h73);
    mouse_left = 1'b0;
    repeat (10) @(negedge clk);

    // Table vectors.
    for (int i = 0; i < 8; i++) begin
      base = wr_q.size();
      h0 = n_hit;
      m0 = n_miss;
      do_click(vecs[i].x, vecs[i].y, vecs[i].value, vecs[i].en, 4);
      check($sformatf("vec%0d_writes", i), 32'(wr_q.size() - base), 32'(vecs[i].kind == 1));
      check($sformatf("vec%0d_hit", i), 32'(n_hit - h0), 32'(vecs[i].kind == 1));
      check($sformatf("vec%0d_miss", i), 32'(n_miss - m0), 32'(vecs[i].kind == 2));
      if (vecs[i].kind == 1 && wr_q.size() > base) begin
        check($sformatf("vec%0d_addr", i), 32'(wr_q[base].addr), 32'(vecs[i].addr));
        check($sformatf("vec%0d_data", i), 32'(wr_q[base].data), 32'(vecs[i].value));
      end
    end

    // Button held for 1000 cycles gives a single write.
    base = wr_q.size();
    h0 = n_hit;
    do_click(300, 300, 2'b10, 1'b1, 1000);
    check("held_writes", 32'(wr_q.size() - base), 32'd1);
    check("held_hit", 32'(n_hit - h0), 32'd1);

    // Randomized clicks against the reference model.
    for (int i = 0; i < 30; i++) begin
      int   x;
      int   y;
      logic [1:0] v;
      logic en;
      bit   is_hit;
      int   exp_addr;
      x  = int'($urandom_range(540, 60));
      y  = int'($urandom_range(640, 160));
      v  = 2'($urandom);
      en = ($urandom_range(7, 0) != 0);
      model(x, y, is_hit, exp_addr);
      base = wr_q.size();
      h0 = n_hit;
      m0 = n_miss;
      do_click(x, y, v, en, 4);
      check($sformatf("rnd%0d_writes(%0d,%0d)", i, x, y), 32'(wr_q.size() - base), 32'(en && is_hit));
      check($sformatf("rnd%0d_hit", i), 32'(n_hit - h0), 32'(en && is_hit));
      check($sformatf("rnd%0d_miss", i), 32'(n_miss - m0), 32'(en && !is_hit));
      if (en && is_hit && wr_q.size() > base) begin
        check($sformatf("rnd%0d_addr", i), 32'(wr_q[base].addr), 32'(exp_addr));
        check($sformatf("rnd%0d_data", i), 32'(wr_q[base].data), 32'(v));
      end
    end

    // clear_req in the same cycle as a press edge: sweep wins, click dropped.
    @(negedge clk);
    mouse_x_pos = 12'd201;
    mouse_y_pos = 12'd425;
    write_value = SHIP;
    enable      = 1'b1;
    mouse_left  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    base = wr_q.size();
    h0 = n_hit;
    m0 = n_miss;
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    wait_sweep("clr");
    mouse_left = 1'b0;
    repeat (10) @(negedge clk);
    check_sweep("clr", base);
    check("clr_hit", 32'(n_hit - h0), 32'd0);
    check("clr_miss", 32'(n_miss - m0), 32'd0);

    // Reset at sweep cell 50, then a full restart from 0x00.
    base = wr_q.size();
    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    n = 0;
    while (wr_q.size() - base < 50 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_reached50", 32'(wr_q.size() - base >= 50), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_we", 32'(write_enable), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_addr", 32'(write_addr), 32'd0);
    check("mid_rst_data", 32'(write_data), 32'd0);
    repeat (3) @(negedge clk);
    base = wr_q.size();
    rst = 1'b1;
    wait_sweep("restart");
    check_sweep("restart", base);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
